stack_ctrl_seq: RTL and testbench
=================================

# stack_ctrl_seq

Multi-cycle control sequencer that drives the stack-processor datapath (expression stack, A/B output registers, 4-entry register file, 16-bit block memory). It accepts one 16-bit stack instruction at a time over a valid/ready handshake and decodes it. It then issues the datapath control strobes (`ESOp`, `ESAct`, `popNum`, `pushSrc`, `push_in`, `wea`, `regWrite`, `regAddress`) with the cycle spacing the datapath's registered A/B outputs and 1-cycle memory read require. It is the initiator side of the datapath's control interface.

## Interface
- `DEPTH`, 16: expression-stack capacity used by the depth checker.
- `clk`  input  1  single clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `instr`  input  16  instruction: [15:12] opcode, [11:0] immediate; [1:0] register index for GETR/SETR.
- `instr_valid`  input  1  instruction offered.
- `instr_ready`  output  1  sequencer can accept; transfer on `instr_valid && instr_ready` at a rising edge.
- `ESOp`  output  2  stack operation: HOLD=00, PUSH=01, POP=10.
- `ESAct`  output  1  one-cycle stack strobe.
- `popNum`  output  1  0 = pop one, 1 = pop two.
- `pushSrc`  output  2  0 zero, 1 `push_in`, 2 memory, 3 register file.
- `push_in`  output  16  zero-extended immediate.
- `wea`  output  1  memory write: mem[A] <= B.
- `regWrite`  output  1  regfile write of A.
- `regAddress`  output  2  regfile index.
- `busy`  output  1  high in any state other than IDLE.
- `halted`  output  1  high in HALT.
- `err`  output  1  sticky stack over/underflow flag.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 PUSHI: push imm.
  - 2 LOAD: push mem[A]; A is not popped.
  - 3 STORE: mem[A] <= B, then pop two.
  - 4 POP: pop one.
  - 5 GETR: push reg[r].
  - 6 SETR: reg[r] <= A, then pop one.
  - 15 HALT.
  - All other opcodes behave as NOP.
- States: IDLE, EXEC, MEMRD, SETTLE, HALT.
- IDLE: `instr_ready`=1; on handshake latch `instr` into IR and go to EXEC.
- EXEC actions and next state:
  - NOP: all strobes low, then IDLE.
  - PUSHI: ESAct=1, ESOp=PUSH, pushSrc=1, then SETTLE.
  - LOAD: all strobes low (memory addressed by A), then MEMRD.
  - STORE: wea=1, ESAct=1, ESOp=POP, popNum=1, then SETTLE.
  - POP: ESAct=1, ESOp=POP, popNum=0, then SETTLE.
  - GETR: regAddress=r, ESAct=1, ESOp=PUSH, pushSrc=3, then SETTLE.
  - SETR: regAddress=r, regWrite=1, ESAct=1, ESOp=POP, popNum=0, then SETTLE.
  - HALT: go to HALT.
- MEMRD: ESAct=1, ESOp=PUSH, pushSrc=2, then SETTLE.
- SETTLE: all strobes low; A/B registers update; then IDLE.
- HALT: absorbing until reset; `instr_ready`=0.
- Strobes are combinational from state and IR. Every strobe is high for exactly one cycle per instruction.

## Timing
- Reset (async assert): state=IDLE, IR=0, err=0, depth=0. Output reset values: `instr_ready`=0 while `reset` is low, then 1 in the first cycle after release; ESOp=HOLD; pushSrc=0; push_in=0; regAddress=0; ESAct, popNum, wea, regWrite, busy, halted all 0.
- Accept at edge k. Next `instr_ready` high at cycle:
  - NOP: k+2.
  - PUSHI, STORE, POP, GETR, SETR: k+3.
  - LOAD: k+4.
- Reset mid-instruction aborts it immediately; the datapath sees no further strobes.
- `instr_valid` while not ready: ignored; no buffering.

## Configuration
- `STK_DEPTH_CHECK_EN` defined:
  - Track depth 0..DEPTH: +1 per push, −1/−2 per pop.
  - Entering EXEC (or MEMRD) with a push at depth==DEPTH, or a pop needing more entries than present (STORE needs 2; POP/SETR need 1): suppress all strobes, set `err`=1, go to HALT.
  - LOAD needs depth≥1 at EXEC.
- Not defined: no counter, no checks, `err` tied 0.

## Structure
- Package `stk_ctrl_pkg`:
  - opcode constants
  - ESOp encodings ES_HOLD/ES_PUSH/ES_POP
  - pushSrc encodings PS_ZERO/PS_IMM/PS_MEM/PS_REG
  - state encoding
- Sub-module `stk_instr_decode`: combinational IR → strobe set and next-state class.

## Test plan
- Reset low mid-EXEC of PUSHI 0x123 -> all strobes 0 immediately; `instr_ready`=1 the cycle after release.
- PUSHI 0x0ABC accepted at edge k -> cycle k+1: ESAct=1, ESOp=01, pushSrc=1, push_in=0x0ABC; `instr_ready` high at k+3.
- LOAD -> EXEC strobes low; MEMRD: ESAct=1, pushSrc=2; ready at k+4.
- STORE -> single EXEC cycle with wea=1, ESOp=10, popNum=1; SETR r=2 -> regWrite=1, regAddress=2, popNum=0.
- With `STK_DEPTH_CHECK_EN`, DEPTH=16: 16 PUSHI then a 17th -> no ESAct, err=1, halted=1. Fresh reset then POP -> err=1.
- HALT then `instr_valid` held high -> `instr_ready` stays 0, halted=1 until reset.

Source files
------------

// File: rtl/stk_ctrl_pkg.sv
// stk_ctrl_pkg: opcodes, datapath control encodings, sequencer states and strobe bundle
package stk_ctrl_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_POP   = 4'd4;
  localparam logic [3:0] OP_GETR  = 4'd5;
  localparam logic [3:0] OP_SETR  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;
  localparam logic [1:0] ES_HOLD = 2'b00;
  localparam logic [1:0] ES_PUSH = 2'b01;
  localparam logic [1:0] ES_POP  = 2'b10;
  localparam logic [1:0] PS_ZERO = 2'd0;
  localparam logic [1:0] PS_IMM  = 2'd1;
  localparam logic [1:0] PS_MEM  = 2'd2;
  localparam logic [1:0] PS_REG  = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_MEMRD, ST_SETTLE, ST_HALT} state_t;
  typedef struct packed {
    logic [1:0] es_op;
    logic       es_act;
    logic       pop_num;
    logic [1:0] push_src;
    logic       wea;
    logic       reg_write;
    logic [1:0] reg_addr;
  } strobes_t;
endpackage

// File: rtl/stack_ctrl_seq_if.sv
// stack_ctrl_seq_if: instruction handshake plus datapath control strobes
interface stack_ctrl_seq_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  ESOp;
  logic        ESAct;
  logic        popNum;
  logic [1:0]  pushSrc;
  logic [15:0] push_in;
  logic        wea;
  logic        regWrite;
  logic [1:0]  regAddress;
  modport master (
    input  instr, instr_valid,
    output instr_ready, ESOp, ESAct, popNum, pushSrc, push_in, wea, regWrite, regAddress
  );
  modport slave (
    output instr, instr_valid,
    input  instr_ready, ESOp, ESAct, popNum, pushSrc, push_in, wea, regWrite, regAddress
  );
endinterface

// File: rtl/stk_instr_decode.sv
// stk_instr_decode: IR opcode/register field to EXEC-cycle strobes and follow-on state
module stk_instr_decode
  import stk_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] r,
  output strobes_t   s,
  output state_t     nxt
);
  logic act;
  always_comb begin
    act = op inside {OP_PUSHI, OP_STORE, OP_POP, OP_GETR, OP_SETR};
    s = '0;
    s.es_act = act;
    s.es_op = op inside {OP_PUSHI, OP_GETR} ? ES_PUSH : act ? ES_POP : ES_HOLD;
    s.pop_num = op == OP_STORE;
    s.push_src = op == OP_PUSHI ? PS_IMM : op == OP_GETR ? PS_REG : PS_ZERO;
    s.wea = op == OP_STORE;
    s.reg_write = op == OP_SETR;
    s.reg_addr = op inside {OP_GETR, OP_SETR} ? r : 2'd0;
    nxt = op == OP_LOAD ? ST_MEMRD : op == OP_HALT ? ST_HALT : act ? ST_SETTLE : ST_IDLE;
  end
endmodule

// File: rtl/stack_ctrl_seq.sv
// stack_ctrl_seq: multi-cycle stack datapath sequencer; define STK_DEPTH_CHECK_EN for over/underflow trapping
module stack_ctrl_seq
  import stk_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  stack_ctrl_seq_if.master bus,
  output logic             busy,
  output logic             halted,
  output logic             err
);
  if (DEPTH < 2 || DEPTH > 4095) begin : g_depth_range
    $error("stack_ctrl_seq: DEPTH out of range");
  end
  state_t      state, nxt, dec_nxt;
  logic [15:0] ir;
  strobes_t    str, dec_str;
  logic        fault;
  stk_instr_decode u_dec (
    .op (ir[15:12]),
    .r  (ir[1:0]),
    .s  (dec_str),
    .nxt(dec_nxt)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && bus.instr_valid) ir <= bus.instr;
    end
  end
  // a trapped check suppresses every strobe of the offending cycle
  always_comb begin
    nxt = state;
    str = '0;
    case (state)
      ST_IDLE: nxt = bus.instr_valid ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        nxt = fault ? ST_HALT : dec_nxt;
        str = fault ? '0 : dec_str;
      end
      ST_MEMRD: begin
        nxt = fault ? ST_HALT : ST_SETTLE;
        str.es_act = !fault;
        str.es_op = fault ? ES_HOLD : ES_PUSH;
        str.push_src = fault ? PS_ZERO : PS_MEM;
      end
      ST_SETTLE: nxt = ST_IDLE;
      default: nxt = ST_HALT;
    endcase
  end
`ifdef STK_DEPTH_CHECK_EN
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  logic [DW-1:0] depth, need;
  logic          push_exec;
  // LOAD needs A present, so it asks for one entry like a single pop
  always_comb begin
    push_exec = dec_str.es_act && dec_str.es_op == ES_PUSH;
    need = dec_str.es_op == ES_POP ? DW'(dec_str.pop_num) + DW'(1) : DW'(ir[15:12] == OP_LOAD);
    fault = state == ST_EXEC ? (push_exec && depth == FULL) || need > depth
          : state == ST_MEMRD && depth == FULL;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (str.es_act) depth <= str.es_op == ES_PUSH ? depth + DW'(1) : depth - DW'(str.pop_num) - DW'(1);
      if (fault) err <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
  assign err   = 1'b0;
`endif
  assign bus.instr_ready = state == ST_IDLE && reset;
  assign bus.ESOp        = str.es_op;
  assign bus.ESAct       = str.es_act;
  assign bus.popNum      = str.pop_num;
  assign bus.pushSrc     = str.push_src;
  assign bus.push_in     = {4'd0, ir[11:0]};
  assign bus.wea         = str.wea;
  assign bus.regWrite    = str.reg_write;
  assign bus.regAddress  = str.reg_addr;
  assign busy            = state != ST_IDLE;
  assign halted          = state == ST_HALT;
endmodule

// File: tb/tb_stack_ctrl_seq.sv
// tb_stack_ctrl_seq: directed checks of strobe timing, reset abort, halt and depth trapping
module tb_stack_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, halted, err;
  int n_chk = 0;
  int n_pass = 0;
  stack_ctrl_seq_if bus ();
  stack_ctrl_seq #(.DEPTH(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .busy  (busy),
    .halted(halted),
    .err   (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w);
    int n = 0;
    while (!bus.instr_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    #12;
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_esact", bus.ESAct, 0);
    chk("rst_esop", bus.ESOp, 0);
    chk("rst_pushsrc", bus.pushSrc, 0);
    chk("rst_pushin", bus.push_in, 0);
    chk("rst_misc", {bus.popNum, bus.wea, bus.regWrite, bus.regAddress, busy, halted, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", bus.instr_ready, 1);
    send(16'h1123);
    chk("abort_pre_esact", bus.ESAct, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_esact", bus.ESAct, 0);
    chk("abort_esop", bus.ESOp, 0);
    chk("abort_pushsrc", bus.pushSrc, 0);
    chk("abort_ready", bus.instr_ready, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", bus.instr_ready, 1);
    send(16'h1ABC);
    chk("pushi_strobes", {bus.ESAct, bus.ESOp, bus.pushSrc}, {1'b1, 2'b01, 2'd1});
    chk("pushi_imm", bus.push_in, 16'h0ABC);
    chk("pushi_busy", {busy, bus.instr_ready}, 2'b10);
    step();
    chk("pushi_settle", {bus.ESAct, bus.instr_ready}, 2'b00);
    step();
    chk("pushi_ready_k3", bus.instr_ready, 1);
    send(16'h2000);
    chk("load_exec", {bus.ESAct, bus.ESOp, bus.wea, bus.regWrite}, 0);
    step();
    chk("load_memrd", {bus.ESAct, bus.ESOp, bus.pushSrc}, {1'b1, 2'b01, 2'd2});
    step();
    chk("load_settle", {bus.ESAct, bus.instr_ready}, 2'b00);
    step();
    chk("load_ready_k4", bus.instr_ready, 1);
    send(16'h5001);
    chk("getr", {bus.ESAct, bus.ESOp, bus.pushSrc, bus.regAddress}, {1'b1, 2'b01, 2'd3, 2'd1});
    step();
    step();
    chk("getr_ready", bus.instr_ready, 1);
    send(16'h3000);
    chk("store", {bus.wea, bus.ESAct, bus.ESOp, bus.popNum, bus.regWrite}, {1'b1, 1'b1, 2'b10, 1'b1, 1'b0});
    step();
    chk("store_settle", {bus.wea, bus.ESAct}, 0);
    step();
    chk("store_ready", bus.instr_ready, 1);
    send(16'h6002);
    chk("setr", {bus.regWrite, bus.regAddress, bus.ESAct, bus.ESOp, bus.popNum}, {1'b1, 2'd2, 1'b1, 2'b10, 1'b0});
    step();
    chk("setr_settle", bus.regWrite, 0);
    step();
    send(16'h0000);
    chk("nop_exec", {bus.ESAct, busy}, 2'b01);
    step();
    chk("nop_ready_k2", bus.instr_ready, 1);
    send(16'h7123);
    chk("undef_exec", {bus.ESAct, bus.wea, bus.regWrite}, 0);
    step();
    chk("undef_ready", bus.instr_ready, 1);
    send(16'h1001);
    step();
    step();
    send(16'h4000);
    chk("pop", {bus.ESAct, bus.ESOp, bus.popNum}, {1'b1, 2'b10, 1'b0});
    step();
    step();
    chk("pop_err", err, 0);
    send(16'hF000);
    chk("halt_exec", {busy, halted}, 2'b10);
    bus.instr = 16'h1005;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_hold", {bus.instr_ready, halted, bus.ESAct}, 3'b010);
    end
    bus.instr_valid = 1'b0;
    do_reset();
    chk("halt_reset", {halted, busy, bus.instr_ready}, 3'b001);
`ifdef STK_DEPTH_CHECK_EN
    for (int i = 0; i < 16; i++) begin
      send(16'h1000 | 16'(i));
      chk("fill_push", bus.ESAct, 1);
    end
    send(16'h1011);
    chk("ovf_no_act", bus.ESAct, 0);
    step();
    chk("ovf_trap", {err, halted}, 2'b11);
    do_reset();
    chk("ovf_err_clr", err, 0);
    send(16'h4000);
    chk("unf_no_act", bus.ESAct, 0);
    step();
    chk("unf_trap", {err, halted}, 2'b11);
    do_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
